fixed_point_dot_accumulator: RTL
================================

# fixed_point_dot_accumulator

Sequencing and accumulation stage wrapped around the 16-bit fixed-point modified-Booth multiplier in the ODE accelerator datapath. It accepts a stream of operand pairs and issues each pair to the multiplier over its start/finish handshake. Each product is summed into a saturating 16-bit accumulator seeded with an initial value, so the block produces terms such as y + Σ hᵢ·fᵢ. One result is presented per vector, terminated by `in_last`. The block is both the multiplier's upstream feeder and its downstream consumer.

## Interface
- `WIDTH`, 16: operand/result width, two's complement; the format is transparent to this block.
- `TIMEOUT`, 64: max cycles in MUL waiting for `mul_finish` before abort.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept a pair.
- `in_a`, `in_b`  in  WIDTH: operands.
- `in_last`  in  1: final pair of vector.
- `acc_init`  in  WIDTH: accumulator seed, sampled with first pair of a vector.
- `mul_a`, `mul_b`  out  WIDTH: multiplier operands, held stable while `mul_start`=1.
- `mul_start`  out  1: multiplier start, level, held until finish seen.
- `mul_result`  in  WIDTH: product.
- `mul_overflow`  in  1: product overflow.
- `mul_finish`  in  1: product valid; stays high until `mul_start` drops.
- `out_valid`  out  1: vector result valid.
- `out_ready`  in  1: consumer accepts result.
- `out_sum`  out  WIDTH: saturated accumulation.
- `out_overflow`  out  1: sticky; any multiplier overflow or accumulator saturation in the vector.
- `out_timeout`  out  1: vector aborted by watchdog.
- `out_count`  out  8: pairs accumulated, saturates at 255.

## Operation
- States: IDLE, MUL, ACC, RELEASE, DONE.
- IDLE: `in_ready`=1. On `in_valid` the block latches a, b and last.
  - If `first` is set, `acc` ← `acc_init`, `ovf`, `count` and `first` are cleared, and the timeout flag is cleared.
  - Transition to MUL.
- MUL: `mul_start`=1, `mul_a`/`mul_b` driven from registers, watchdog counting.
  - On `mul_finish`=1: capture the product, OR `mul_overflow` into `ovf`, go to ACC.
  - If the watchdog reaches `TIMEOUT`: set `timeout`, go to DONE with no accumulation.
- ACC: `mul_start`=0.
  - Compute `acc + product` at WIDTH+1 bits. On signed overflow, clamp to 0x7FFF or 0x8000 and set `ovf`.
  - `count` += 1, saturating.
  - Go to RELEASE.
- RELEASE: wait for `mul_finish`=0, then go to DONE if last, otherwise IDLE.
- DONE: `out_valid`=1 and outputs are stable. On `out_ready`, set `first` and go to IDLE.
- `in_ready` is 0 in every state except IDLE. A pair is never lost, since the upstream holds it while `in_ready`=0.
- `out_ready` outside DONE is ignored.
- A single-pair vector has `in_last`=1 on the first beat.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after.
  - Zero on reset: `mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_sum`, `out_overflow`, `out_timeout`, `out_count`.
  - State → IDLE, `first`=1.
- Reset mid-operation (any state) returns to IDLE next edge. `mul_start` drops immediately and the partial vector is discarded.
- Per-pair latency is 1 (accept) + L (multiplier cycles to finish) + 1 (ACC) + ≥1 (RELEASE).
- `out_valid` rises the cycle after RELEASE completes for the last pair.
- `mul_start` never rises while `mul_finish`=1, which guarantees a clean multiplier restart.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package/include `fixed_point_pkg`: `WIDTH`, `SAT_MAX`=0x7FFF, `SAT_MIN`=0x8000, state encoding.
- One sub-module, `saturating_adder`: combinational WIDTH-bit add with clamp and overflow out. It is reused by later ODE stages.

## Test plan
Values are Q8.8; the bench multiplier model has programmable latency L.
1. Single pair 0x0200×0x0180, `acc_init`=0x0100, L=8 -> `out_sum`=0x0400, `out_count`=1, flags 0.
2. Three pairs (0x0100×0x0100)×3, `acc_init`=0, `out_ready` held low 5 cycles -> 0x0300 stays stable until accepted; `in_ready` stays 0 while DONE.
3. `acc_init`=0x7F00 + product 0x0200 -> `out_sum`=0x7FFF, `out_overflow`=1; the next vector starts with flags cleared.
4. Model asserts `mul_overflow` on the second of two pairs -> `out_overflow`=1, sum still accumulated.
5. Model never asserts finish -> after 64 MUL cycles, `out_timeout`=1, `mul_start`=0, `out_valid`=1.
6. `rst_n` low for one cycle during MUL -> next cycle IDLE, `mul_start`=0, `out_valid`=0, and the following vector's result is unaffected.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg
// Shared definitions for the ODE accelerator fixed-point stages: datapath
// width, saturation limits and the dot-accumulator state encoding.
package fixed_point_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_ACC     = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/saturating_adder.sv
// saturating_adder
// Combinational two's-complement add that clamps to the most positive or
// most negative representable value instead of wrapping.
// Ports:
//   a, b : addends (WIDTH bits, signed)
//   sum  : clamped result
//   ovf  : 1 when the true sum did not fit and was clamped
module saturating_adder #(
  parameter int WIDTH = fixed_point_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] ext;

  always_comb begin
    ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // The two top bits disagree exactly when the result left the range;
    // the extra sign bit tells which way.
    ovf = ext[WIDTH] ^ ext[WIDTH-1];
    if (ovf) sum = ext[WIDTH] ? MIN_V : MAX_V;
    else     sum = ext[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_point_dot_accumulator.sv
// fixed_point_dot_accumulator
// Feeds operand pairs to the external Booth multiplier over its level
// start/finish handshake and sums each product into a saturating
// accumulator seeded per vector, producing y + sum(h_i * f_i).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : operand pair handshake (in_a, in_b, in_last)
//   acc_init                   : seed, taken with the first pair of a vector
//   mul_a, mul_b, mul_start    : multiplier request (start held until finish)
//   mul_result, mul_overflow,
//   mul_finish                 : multiplier response
//   out_valid/out_ready        : result handshake
//   out_sum, out_overflow,
//   out_timeout, out_count     : per-vector result and status
//
// state   | meaning
// IDLE    | ready for the next pair
// MUL     | start asserted, watchdog running, waiting for finish
// ACC     | add captured product into the accumulator
// RELEASE | start dropped, waiting for finish to fall
// DONE    | result presented until out_ready
module fixed_point_dot_accumulator #(
  parameter int WIDTH   = fixed_point_pkg::WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  input  logic [WIDTH-1:0] acc_init,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_start,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_overflow,
  input  logic             mul_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic             out_timeout,
  output logic [7:0]       out_count
);

  import fixed_point_pkg::*;

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t state, state_nxt;

  logic              in_ready_q, mul_start_q, out_valid_q;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, prod_q;
  logic              last_q, first_q, ovf_q, timeout_q;
  logic [7:0]        count_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [WIDTH-1:0]  acc_sum;
  logic              acc_ovf;

  saturating_adder #(.WIDTH(WIDTH)) u_sat_add (
    .a   (acc_q),
    .b   (prod_q),
    .sum (acc_sum),
    .ovf (acc_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (in_valid && in_ready_q) state_nxt = S_MUL;
      S_MUL: begin
        if (mul_finish)          state_nxt = S_ACC;
        else if (wdog_q == '0)   state_nxt = S_DONE;
      end
      S_ACC:     state_nxt = S_RELEASE;
      S_RELEASE: if (!mul_finish) state_nxt = last_q ? S_DONE : S_IDLE;
      S_DONE:    if (out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs are flops loaded from the next state so nothing
  // combinational reaches a port. in_ready also waits for a stale finish
  // (e.g. after a reset mid-multiply) to fall, so start never rises onto it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nxt == S_IDLE) && !mul_finish;
      mul_start_q <= (state_nxt == S_MUL);
      out_valid_q <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      last_q    <= 1'b0;
      first_q   <= 1'b1;
      acc_q     <= '0;
      prod_q    <= '0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      wdog_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q    <= in_a;
            b_q    <= in_b;
            last_q <= in_last;
            wdog_q <= WDOG_W'(TIMEOUT - 1);
            if (first_q) begin
              acc_q     <= acc_init;
              ovf_q     <= 1'b0;
              count_q   <= '0;
              first_q   <= 1'b0;
              timeout_q <= 1'b0;
            end
          end
        end
        S_MUL: begin
          if (mul_finish) begin
            prod_q <= mul_result;
            ovf_q  <= ovf_q | mul_overflow;
          end else if (wdog_q == '0) begin
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q - 1'b1;
          end
        end
        S_ACC: begin
          acc_q <= acc_sum;
          ovf_q <= ovf_q | acc_ovf;
          if (count_q != 8'hFF) count_q <= count_q + 8'd1;
        end
        S_DONE: begin
          if (out_ready) first_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mul_start    = mul_start_q;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_timeout  = timeout_q;
  assign out_count    = count_q;

endmodule
